cursor_cmd_scheduler: RTL and testbench
=======================================

# cursor_cmd_scheduler

- Sits between the keyboard receive FIFO and the cursor position registers.
- Owns the FIFO read side: pops ASCII bytes one at a time only when the FIFO is non-empty, decodes WASD move commands and applies wrapped position updates.
- Enforces a configurable cooldown between moves.
- Arbitrates a host "set position" requester against keyboard traffic. The host has priority and uses a level request/acknowledge handshake.

## Interface

Parameters:

- X_MAX, 4, largest x value; x range 0..X_MAX, must be ≤ 255
- Y_MAX, 4, largest y value; y range 0..Y_MAX, must be ≤ 255
- COOLDOWN, 0, idle cycles inserted after each applied keyboard byte; 0 disables cooldown

Ports:

- One clock; reset is asynchronous and active-high.
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- fifo_empty  in  1  FIFO empty flag
- fifo_dout  in  8  FIFO read data, valid the cycle after a fifo_r_en pulse
- fifo_r_en  out  1  one-cycle FIFO pop strobe
- set_req  in  1  host position-set request, level
- set_x  in  8  requested x
- set_y  in  8  requested y
- set_ack  out  1  one-cycle acknowledge of a set request
- x  out  8  cursor x
- y  out  8  cursor y
- move_valid  out  1  one-cycle pulse, cursor moved by a key
- move_dir  out  2  last move direction: 0 = up (W), 1 = left (A), 2 = down (S), 3 = right (D)
- ignored_cnt  out  8  saturating count of popped non-WASD bytes
- busy  out  1  high in every state except IDLE

## Operation

**States:** IDLE, READ, CAPTURE, APPLY, COOLDOWN, SET_WAIT.

**IDLE**
- If set_req = 1: load x ← min(set_x, X_MAX) and y ← min(set_y, Y_MAX), pulse set_ack, go to SET_WAIT.
- Else if fifo_empty = 0: go to READ.
- Else stay in IDLE.
- The host request always wins over a pending keyboard byte.

**READ**
- fifo_r_en = 1 for exactly this cycle. It is a Moore output of the state register.
- Go to CAPTURE.

**CAPTURE**
- Latch fifo_dout into the command register.
- Go to APPLY.

**APPLY**
- Decode the command register. Upper- and lower-case letters are equivalent:
  - W (0x77 / 0x57): y ← (y == Y_MAX) ? 0 : y + 1
  - S (0x73 / 0x53): y ← (y == 0) ? Y_MAX : y − 1
  - D (0x64 / 0x44): x ← (x == X_MAX) ? 0 : x + 1
  - A (0x61 / 0x41): x ← (x == 0) ? X_MAX : x − 1
- On a WASD byte: move_valid pulses and move_dir is updated.
- On any other byte: position is unchanged, ignored_cnt increments and saturates at 255, move_valid stays low.
- Go to COOLDOWN if COOLDOWN > 0, else IDLE.

**COOLDOWN**
- The counter runs 0..COOLDOWN−1, then the block returns to IDLE.
- If set_req = 1 during COOLDOWN, the set is serviced exactly as in IDLE (load, set_ack, go to SET_WAIT) and the cooldown is abandoned.

**SET_WAIT**
- Stay until set_req = 0, then go to IDLE.
- This prevents one request from being serviced twice.
- FIFO bytes wait in the FIFO during SET_WAIT.

**General rules**
- All arithmetic is 8-bit.
- Wrap is computed by comparison against the bounds, never by a modulo operator.
- fifo_r_en is never asserted while fifo_empty was 1 at the IDLE decision.
- Exactly one pop per READ visit.

## Timing

**Reset values:** state IDLE, x = 1, y = 1, fifo_r_en = 0, set_ack = 0, move_valid = 0, move_dir = 0, ignored_cnt = 0, busy = 0, cooldown counter = 0.

**Reset mid-operation**
- Reset acts immediately (asynchronous).
- A byte that was popped but not yet applied is lost.

**Keyboard path latency**, counted from edge E0 (IDLE samples fifo_empty = 0):
- E1: READ → CAPTURE; the FIFO advances on this edge.
- E2: command latched.
- E3: x/y updated; move_valid is high for the single cycle after E3.
- Throughput: one byte per 4 + COOLDOWN cycles.

**Set path**
- On the edge where IDLE/COOLDOWN samples set_req = 1: x/y load and set_ack rises.
- set_ack lasts exactly one cycle, even if set_req stays high.

**Simultaneous events**
- set_req = 1 together with fifo_empty = 0 in IDLE: the set wins and no pop occurs.
- set_req rising during READ/CAPTURE/APPLY: the keyboard sequence completes first; the set is serviced at the next IDLE/COOLDOWN.

**Output registering:** move_valid, set_ack, x, y, move_dir and ignored_cnt are registered.

## Test plan

- After reset, FIFO supplies 0x64, 0x64, 0x64, 0x64 (D ×4), COOLDOWN = 0, X_MAX = 4:
  - x sequence 2, 3, 4, 0.
  - Four move_valid pulses.
  - move_dir = 3.
  - Bytes applied 4 cycles apart.
- Reset, then 0x61 0x61 (A ×2) → x = 0, then x = 4. Then 0x53 0x53 (S ×2) → y = 0, then y = 4.
- FIFO supplies 0x5A ('Z') then 0x57 ('W'):
  - ignored_cnt = 1.
  - No move_valid for 'Z'.
  - y goes 1 → 2 on 'W'.
  - Exactly two fifo_r_en pulses.
- set_req = 1 with set_x = 9, set_y = 3 and FIFO non-empty in the same IDLE cycle:
  - x = 4 (clamped), y = 3.
  - set_ack for one cycle.
  - No fifo_r_en while set_req is held.
  - After set_req drops, the queued byte is popped.
- COOLDOWN = 5, two queued 'D' bytes:
  - The second fifo_r_en comes exactly 9 cycles after the first.
  - A set_req asserted during cooldown is acked on the next edge and aborts the cooldown.
- Assert reset in CAPTURE after a pop:
  - Outputs return to reset values immediately (x = 1, y = 1).
  - No move_valid is produced for the popped byte.

Source files
------------

// File: rtl/cursor_cmd_scheduler_if.sv
// ---------------------------------------------------------------------------
// cursor_cmd_scheduler_if
//   Bundles the keyboard FIFO read side, the host set-position handshake and
//   the cursor status outputs of cursor_cmd_scheduler.
//
//   FIFO side : fifo_empty, fifo_dout (data valid the cycle after a pop),
//               fifo_r_en (one-cycle pop strobe)
//   Host side : set_req (level), set_x, set_y, set_ack (one-cycle pulse)
//   Status    : x, y, move_valid, move_dir, ignored_cnt, busy
//
//   master : the environment (FIFO + host + position consumer)
//   slave  : the scheduler
// ---------------------------------------------------------------------------
interface cursor_cmd_scheduler_if;
  logic       fifo_empty;
  logic [7:0] fifo_dout;
  logic       fifo_r_en;
  logic       set_req;
  logic [7:0] set_x;
  logic [7:0] set_y;
  logic       set_ack;
  logic [7:0] x;
  logic [7:0] y;
  logic       move_valid;
  logic [1:0] move_dir;
  logic [7:0] ignored_cnt;
  logic       busy;

  modport master (
    output fifo_empty, fifo_dout, set_req, set_x, set_y,
    input  fifo_r_en, set_ack, x, y, move_valid, move_dir, ignored_cnt, busy
  );

  modport slave (
    input  fifo_empty, fifo_dout, set_req, set_x, set_y,
    output fifo_r_en, set_ack, x, y, move_valid, move_dir, ignored_cnt, busy
  );
endinterface

// File: rtl/cursor_cmd_scheduler.sv
// ---------------------------------------------------------------------------
// cursor_cmd_scheduler
//   Pops ASCII bytes from the keyboard FIFO, decodes WASD moves and applies
//   wrapped cursor updates, with an optional cooldown after every applied
//   byte. A host set-position request has priority over keyboard traffic.
//
//   Parameters : X_MAX, Y_MAX (inclusive bounds, <= 255), COOLDOWN (idle
//                cycles after each applied byte, 0 disables)
//   Ports      : i_clk  system clock
//                i_rst  asynchronous active-high reset
//                bus    cursor_cmd_scheduler_if.slave (FIFO, host, status)
//
//   state      | meaning
//   -----------+-------------------------------------------------------------
//   S_IDLE     | waiting; host set has priority over a non-empty FIFO
//   S_READ     | fifo_r_en high for this single cycle
//   S_CAPTURE  | fifo_dout latched into r_cmd
//   S_APPLY    | r_cmd decoded, position / ignored count updated
//   S_COOLDOWN | r_cd counts 0..COOLDOWN-1; host set may still be serviced
//   S_SET_WAIT | set acknowledged, waiting for set_req to drop
// ---------------------------------------------------------------------------
module cursor_cmd_scheduler #(
  parameter int X_MAX    = 4,
  parameter int Y_MAX    = 4,
  parameter int COOLDOWN = 0
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  cursor_cmd_scheduler_if.slave   bus
);

  localparam logic [7:0] XM = 8'(X_MAX);
  localparam logic [7:0] YM = 8'(Y_MAX);
  localparam int         CW = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;
  localparam logic [CW-1:0] CD_LAST = CW'(COOLDOWN - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_CAPTURE,
    S_APPLY,
    S_COOLDOWN,
    S_SET_WAIT
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [7:0]    r_cmd;
  logic [7:0]    r_x;
  logic [7:0]    r_y;
  logic [1:0]    r_dir;
  logic [7:0]    r_ign;
  logic          r_mv;
  logic          r_ack;
  logic [CW-1:0] r_cd;

  logic          w_take_set;
  logic [7:0]    w_cmd_lc;
  logic [7:0]    w_clamp_x;
  logic [7:0]    w_clamp_y;

  // Folding bit 5 maps 'W'/'A'/'S'/'D' onto their lower-case codes; no other
  // byte lands on one of the four lower-case codes.
  assign w_cmd_lc   = r_cmd | 8'h20;
  assign w_take_set = bus.set_req && (r_state == S_IDLE || r_state == S_COOLDOWN);
  assign w_clamp_x  = (bus.set_x > XM) ? XM : bus.set_x;
  assign w_clamp_y  = (bus.set_y > YM) ? YM : bus.set_y;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.set_req)          w_next = S_SET_WAIT;
        else if (!bus.fifo_empty) w_next = S_READ;
      end
      S_READ:    w_next = S_CAPTURE;
      S_CAPTURE: w_next = S_APPLY;
      S_APPLY:   w_next = (COOLDOWN > 0) ? S_COOLDOWN : S_IDLE;
      S_COOLDOWN: begin
        if (bus.set_req)          w_next = S_SET_WAIT;
        else if (r_cd == CD_LAST) w_next = S_IDLE;
      end
      S_SET_WAIT: begin
        if (!bus.set_req)         w_next = S_IDLE;
      end
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_cmd   <= 8'd0;
      r_x     <= 8'd1;
      r_y     <= 8'd1;
      r_dir   <= 2'd0;
      r_ign   <= 8'd0;
      r_mv    <= 1'b0;
      r_ack   <= 1'b0;
      r_cd    <= '0;
    end else begin
      r_state <= w_next;
      r_mv    <= 1'b0;
      r_ack   <= 1'b0;

      if (w_take_set) begin
        r_x   <= w_clamp_x;
        r_y   <= w_clamp_y;
        r_ack <= 1'b1;
      end

      if (r_state == S_CAPTURE) r_cmd <= bus.fifo_dout;

      if (r_state == S_APPLY) begin
        case (w_cmd_lc)
          8'h77: begin
            r_y   <= (r_y == YM) ? 8'd0 : r_y + 8'd1;
            r_dir <= 2'd0;
            r_mv  <= 1'b1;
          end
          8'h61: begin
            r_x   <= (r_x == 8'd0) ? XM : r_x - 8'd1;
            r_dir <= 2'd1;
            r_mv  <= 1'b1;
          end
          8'h73: begin
            r_y   <= (r_y == 8'd0) ? YM : r_y - 8'd1;
            r_dir <= 2'd2;
            r_mv  <= 1'b1;
          end
          8'h64: begin
            r_x   <= (r_x == XM) ? 8'd0 : r_x + 8'd1;
            r_dir <= 2'd3;
            r_mv  <= 1'b1;
          end
          default: begin
            if (r_ign != 8'hFF) r_ign <= r_ign + 8'd1;
          end
        endcase
      end

      // Counter only advances while cooling down; any exit clears it so the
      // next cooldown starts from zero.
      if (r_state == S_COOLDOWN && !w_take_set) r_cd <= r_cd + CW'(1);
      else                                      r_cd <= '0;
    end
  end

  assign bus.fifo_r_en   = (r_state == S_READ);
  assign bus.busy        = (r_state != S_IDLE);
  assign bus.set_ack     = r_ack;
  assign bus.x           = r_x;
  assign bus.y           = r_y;
  assign bus.move_valid  = r_mv;
  assign bus.move_dir    = r_dir;
  assign bus.ignored_cnt = r_ign;

endmodule

// File: tb/tb_cursor_cmd_scheduler.sv
// ---------------------------------------------------------------------------
// tb_cursor_cmd_scheduler
//   Two schedulers (COOLDOWN = 0 and COOLDOWN = 5) run side by side from
//   separate FIFO queues holding the same byte stream, with a shared host
//   requester. A timeline model (when the block is next free, when a popped
//   byte lands) predicts every output in every cycle.
// ---------------------------------------------------------------------------
module tb_cursor_cmd_scheduler;

  localparam int XM = 4;
  localparam int YM = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cursor_cmd_scheduler_if if0 ();
  cursor_cmd_scheduler_if if1 ();

  cursor_cmd_scheduler #(.X_MAX(XM), .Y_MAX(YM), .COOLDOWN(0)) u_dut0 (
    .i_clk(clk), .i_rst(rst), .bus(if0.slave)
  );
  cursor_cmd_scheduler #(.X_MAX(XM), .Y_MAX(YM), .COOLDOWN(5)) u_dut1 (
    .i_clk(clk), .i_rst(rst), .bus(if1.slave)
  );

  logic [7:0] fq0[$];
  logic [7:0] fq1[$];
  logic       set_req_v = 1'b0;
  logic [7:0] sx = 8'd0;
  logic [7:0] sy = 8'd0;
  int         cyc = 0;
  int         n_vec = 0;
  int         n_err = 0;

  // model state
  int         mx[2], my[2], mign[2], mdir[2];
  logic       e_mv[2], e_ack[2], e_ren[2], e_busy[2];
  int         idle_at[2], set_at[2], apply_at[2];
  bit         swait[2];
  logic [7:0] pend[2];
  bit         ren_seen[2];
  int         mv_cnt[2];

  function automatic int cd_of(input int k);
    return (k == 0) ? 0 : 5;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mx[k] = 1; my[k] = 1; mign[k] = 0; mdir[k] = 0;
      e_mv[k] = 0; e_ack[k] = 0; e_ren[k] = 0; e_busy[k] = 0;
      idle_at[k] = 0; set_at[k] = 0; apply_at[k] = -1;
      swait[k] = 0; ren_seen[k] = 0;
    end
  endtask

  task automatic model_next(input int k, input bit empty);
    e_ren[k] = 0; e_ack[k] = 0; e_mv[k] = 0;
    if (apply_at[k] == cyc + 1) begin
      case (pend[k])
        8'h77, 8'h57: begin my[k] = (my[k] + 1) % (YM + 1);  mdir[k] = 0; e_mv[k] = 1; end
        8'h61, 8'h41: begin mx[k] = (mx[k] + XM) % (XM + 1); mdir[k] = 1; e_mv[k] = 1; end
        8'h73, 8'h53: begin my[k] = (my[k] + YM) % (YM + 1); mdir[k] = 2; e_mv[k] = 1; end
        8'h64, 8'h44: begin mx[k] = (mx[k] + 1) % (XM + 1);  mdir[k] = 3; e_mv[k] = 1; end
        default:      if (mign[k] < 255) mign[k]++;
      endcase
    end
    if (swait[k]) begin
      if (!set_req_v) begin
        swait[k] = 0; idle_at[k] = cyc + 1; set_at[k] = cyc + 1;
      end
    end else if (cyc >= set_at[k] && set_req_v) begin
      mx[k] = (sx > XM) ? XM : int'(sx);
      my[k] = (sy > YM) ? YM : int'(sy);
      e_ack[k] = 1; swait[k] = 1;
    end else if (cyc >= idle_at[k] && !empty) begin
      // READ next cycle, byte lands three cycles after that
      e_ren[k]    = 1;
      apply_at[k] = cyc + 4;
      set_at[k]   = cyc + 4;
      idle_at[k]  = cyc + 4 + cd_of(k);
    end
    e_busy[k] = swait[k] || (cyc + 1 < idle_at[k]);
  endtask

  task automatic cmp(input int k, input string pfx);
    logic [7:0] ox, oy, oign;
    logic [1:0] odir;
    logic       omv, oack, oren, obusy;
    if (k == 0) begin
      ox = if0.x; oy = if0.y; oign = if0.ignored_cnt; odir = if0.move_dir;
      omv = if0.move_valid; oack = if0.set_ack; oren = if0.fifo_r_en; obusy = if0.busy;
    end else begin
      ox = if1.x; oy = if1.y; oign = if1.ignored_cnt; odir = if1.move_dir;
      omv = if1.move_valid; oack = if1.set_ack; oren = if1.fifo_r_en; obusy = if1.busy;
    end
    chk($sformatf("%s_x%0d", pfx, k),    32'(ox),    32'(mx[k]));
    chk($sformatf("%s_y%0d", pfx, k),    32'(oy),    32'(my[k]));
    chk($sformatf("%s_ign%0d", pfx, k),  32'(oign),  32'(mign[k]));
    chk($sformatf("%s_dir%0d", pfx, k),  32'(odir),  32'(mdir[k]));
    chk($sformatf("%s_mv%0d", pfx, k),   32'(omv),   32'(e_mv[k]));
    chk($sformatf("%s_ack%0d", pfx, k),  32'(oack),  32'(e_ack[k]));
    chk($sformatf("%s_ren%0d", pfx, k),  32'(oren),  32'(e_ren[k]));
    chk($sformatf("%s_busy%0d", pfx, k), 32'(obusy), 32'(e_busy[k]));
    if (omv === 1'b1) mv_cnt[k]++;
    ren_seen[k] = (oren === 1'b1);
  endtask

  function automatic logic [7:0] gen_byte();
    logic [7:0] wasd[8];
    wasd = '{8'h77, 8'h57, 8'h73, 8'h53, 8'h64, 8'h44, 8'h61, 8'h41};
    if ($urandom_range(7) < 6) return wasd[$urandom_range(7)];
    return 8'($urandom_range(255));
  endfunction

  // push_mode: 0 none, 1 random bytes, 2 non-WASD bytes only
  task automatic step(input bit do_rst, input int push_mode, input bit stim_set);
    logic [7:0] b;
    @(posedge clk);
    cyc++;
    #1;
    if (rst && !do_rst) rst = 1'b0;
    if (ren_seen[0]) begin
      chk("pop_nonempty0", 32'(fq0.size() != 0), 32'd1);
      if (fq0.size() != 0) begin if0.fifo_dout = fq0.pop_front(); pend[0] = if0.fifo_dout; end
    end
    if (ren_seen[1]) begin
      chk("pop_nonempty1", 32'(fq1.size() != 0), 32'd1);
      if (fq1.size() != 0) begin if1.fifo_dout = fq1.pop_front(); pend[1] = if1.fifo_dout; end
    end
    if (push_mode != 0 && fq0.size() < 6 && fq1.size() < 6 && $urandom_range(2) == 0) begin
      b = (push_mode == 1) ? gen_byte() : 8'(8'h30 + $urandom_range(9));
      fq0.push_back(b);
      fq1.push_back(b);
    end
    if (stim_set) begin
      if (!set_req_v) begin
        if ($urandom_range(19) == 0) begin
          set_req_v = 1'b1;
          sx = 8'($urandom_range(9));
          sy = 8'($urandom_range(9));
        end
      end else if ($urandom_range(2) == 0) begin
        set_req_v = 1'b0;
      end
    end
    if0.set_req = set_req_v; if1.set_req = set_req_v;
    if0.set_x = sx; if1.set_x = sx;
    if0.set_y = sy; if1.set_y = sy;
    if0.fifo_empty = (fq0.size() == 0);
    if1.fifo_empty = (fq1.size() == 0);
    if (do_rst) begin
      rst = 1'b1;
      #1;
      model_reset();
      cmp(0, "rst");
      cmp(1, "rst");
    end
    @(negedge clk);
    cmp(0, "cyc");
    cmp(1, "cyc");
    if (!rst) begin
      model_next(0, fq0.size() == 0);
      model_next(1, fq1.size() == 0);
    end
  endtask

  initial begin
    if0.fifo_empty = 1'b1; if1.fifo_empty = 1'b1;
    if0.fifo_dout = 8'd0;  if1.fifo_dout = 8'd0;
    if0.set_req = 1'b0;    if1.set_req = 1'b0;
    if0.set_x = 8'd0; if0.set_y = 8'd0; if1.set_x = 8'd0; if1.set_y = 8'd0;
    mv_cnt[0] = 0; mv_cnt[1] = 0;
    model_reset();

    // D x4 straight out of reset
    repeat (4) begin fq0.push_back(8'h64); fq1.push_back(8'h64); end
    step(1'b1, 0, 1'b0);
    repeat (45) step(1'b0, 0, 1'b0);
    chk("d4_x0", 32'(if0.x), 32'd0);
    chk("d4_x1", 32'(if1.x), 32'd0);
    chk("d4_dir0", 32'(if0.move_dir), 32'd3);
    chk("d4_mv0", 32'(mv_cnt[0]), 32'd4);
    chk("d4_mv1", 32'(mv_cnt[1]), 32'd4);

    // random traffic with a reset landing in CAPTURE after each block
    for (int blk = 0; blk < 4; blk++) begin
      repeat (500) step(1'b0, 1, 1'b1);
      set_req_v = 1'b0;
      for (int i = 0; i < 300 && !ren_seen[0]; i++) begin
        if (fq0.size() == 0) begin fq0.push_back(8'h77); fq1.push_back(8'h77); end
        step(1'b0, 0, 1'b0);
      end
      chk("midrst_pop_seen", 32'(ren_seen[0]), 32'd1);
      step(1'b1, 0, 1'b0);
      repeat (2) step(1'b0, 0, 1'b0);
    end

    // non-WASD flood to reach ignored_cnt saturation
    set_req_v = 1'b0;
    repeat (3000) step(1'b0, 2, 1'b0);
    chk("ign_sat0", 32'(if0.ignored_cnt), 32'd255);
    chk("ign_sat1", 32'(if1.ignored_cnt), 32'd255);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
